// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32 x 32-bit RV32I integer register file.
// Fed by the MEM/WB pipeline register. It has two combinational read
// ports for decode and an optional same-cycle write-to-read bypass.
// x0 has no storage and always reads 0.
module rv32i_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              werf_in,
    input  logic [ADDR_W-1:0] write_addr_in,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Index 0 is deliberately absent: x0 is hard-wired to zero.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];

    logic              wr_fire;
    logic [DATA_W-1:0] rs1_stored;
    logic [DATA_W-1:0] rs2_stored;
    logic              rs1_hit;
    logic              rs2_hit;

    // A write qualifies only out of reset, when enabled and not aimed at x0.
    // The bypass uses the same term, so it is also suppressed during reset.
    assign wr_fire = reset & werf_in & (write_addr_in != '0);

    // Next-state array: copy the current contents, then overlay the single write.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_fire && (write_addr_in == ADDR_W'(i))) begin
                regs_d[i] = wb_data_in;
            end
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes. Address 0 falls through to the zero default.
    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rs1_addr == ADDR_W'(i)) rs1_stored = regs_q[i];
            if (rs2_addr == ADDR_W'(i)) rs2_stored = regs_q[i];
        end
    end

    // Bypass hits are evaluated per port, so both ports may forward the same rd.
    always_comb begin
        rs1_hit = (BYPASS != 0) && wr_fire && (write_addr_in == rs1_addr);
        rs2_hit = (BYPASS != 0) && wr_fire && (write_addr_in == rs2_addr);
    end

    // Output selection. During reset, force 0 regardless of the flop state.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (reset) begin
            rs1_data = rs1_hit ? wb_data_in : rs1_stored;
            rs2_data = rs2_hit ? wb_data_in : rs2_stored;
        end
    end

endmodule

// File: tb/tb_rv32i_regfile.sv
// tb_rv32i_regfile: directed checks of the register file.
// Two instances share the same stimulus: one with bypass and one without.
module tb_rv32i_regfile;

    logic        clk;
    logic        reset;
    logic        werf_in;
    logic [4:0]  write_addr_in;
    logic [31:0] wb_data_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rs1_data_nb;
    logic [31:0] rs2_data_nb;

    int errors = 0;
    int checks = 0;

    rv32i_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .werf_in       (werf_in),
        .write_addr_in (write_addr_in),
        .wb_data_in    (wb_data_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data)
    );

    rv32i_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
        .clk           (clk),
        .reset         (reset),
        .werf_in       (werf_in),
        .write_addr_in (write_addr_in),
        .wb_data_in    (wb_data_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data_nb),
        .rs2_data      (rs2_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        werf_in       = 1'b1;
        write_addr_in = a;
        wb_data_in    = d;
        tick();
        werf_in       = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        werf_in       = 1'b0;
        write_addr_in = '0;
        wb_data_in    = '0;
        rs1_addr      = 5'd5;
        rs2_addr      = 5'd5;
        #1;
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2_nb", rs2_data_nb, 32'h0);

        // A write during reset must neither bypass nor land.
        werf_in       = 1'b1;
        write_addr_in = 5'd5;
        wb_data_in    = 32'hCAFEF00D;
        #1;
        check("reset_no_bypass", rs1_data, 32'h0);
        tick();
        werf_in = 1'b0;
        check("reset_write_dropped", rs1_data, 32'h0);

        // Release between edges; the first edge afterwards writes.
        reset = 1'b1;
        wr(5'd5, 32'hDEADBEEF);
        check("x5_written", rs1_data, 32'hDEADBEEF);
        check("x5_written_nb", rs2_data_nb, 32'hDEADBEEF);

        // Asynchronous clear in mid-cycle, with no clock edge involved.
        reset = 1'b0;
        #1;
        check("async_clear", rs1_data, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i + 1);
            #1;
            check($sformatf("cleared_rs1_x%0d", i), rs1_data, 32'h0);
            check($sformatf("cleared_rs2_x%0d", 32 - i), rs2_data_nb, 32'h0);
        end

        // Basic write and read on both ports.
        tick();
        wr(5'd10, 32'h12345678);
        rs1_addr = 5'd10;
        rs2_addr = 5'd10;
        #1;
        check("basic_rs1", rs1_data, 32'h12345678);
        check("basic_rs2", rs2_data, 32'h12345678);
        check("basic_rs1_nb", rs1_data_nb, 32'h12345678);

        // A write to x0 does not change it, and it does not bypass.
        werf_in       = 1'b1;
        write_addr_in = 5'd0;
        wb_data_in    = 32'hFFFFFFFF;
        rs1_addr      = 5'd0;
        #1;
        check("x0_same_cycle", rs1_data, 32'h0);
        tick();
        werf_in = 1'b0;
        check("x0_after", rs1_data, 32'h0);
        check("x0_after_nb", rs1_data_nb, 32'h0);
        check("x10_untouched", rs2_data, 32'h12345678);

        // Bypass behaviour against the no-bypass instance.
        wr(5'd7, 32'h00000001);
        wr(5'd8, 32'h00000088);
        werf_in       = 1'b1;
        write_addr_in = 5'd7;
        wb_data_in    = 32'hA5A5A5A5;
        rs1_addr      = 5'd7;
        rs2_addr      = 5'd8;
        #1;
        check("byp_rs1", rs1_data, 32'hA5A5A5A5);
        check("byp_rs2_other", rs2_data, 32'h00000088);
        check("nobyp_rs1_old", rs1_data_nb, 32'h00000001);
        rs2_addr = 5'd7;
        #1;
        check("byp_both_ports", rs2_data, 32'hA5A5A5A5);
        check("nobyp_rs2_old", rs2_data_nb, 32'h00000001);
        tick();
        werf_in = 1'b0;
        check("nobyp_rs1_next", rs1_data_nb, 32'hA5A5A5A5);
        check("byp_rs1_stored", rs1_data, 32'hA5A5A5A5);

        // With the write disabled, the array is unchanged and nothing bypasses.
        wr(5'd3, 32'h00000033);
        werf_in       = 1'b0;
        write_addr_in = 5'd3;
        wb_data_in    = 32'h00000055;
        rs1_addr      = 5'd3;
        #1;
        check("wdis_no_bypass", rs1_data, 32'h00000033);
        tick();
        check("wdis_unchanged", rs1_data, 32'h00000033);
        check("wdis_unchanged_nb", rs1_data_nb, 32'h00000033);

        // Reset held across the edge of a pending write: the write is dropped.
        werf_in       = 1'b1;
        write_addr_in = 5'd12;
        wb_data_in    = 32'h00000099;
        reset         = 1'b0;
        tick();
        reset   = 1'b1;
        werf_in = 1'b0;
        rs1_addr = 5'd12;
        rs2_addr = 5'd10;
        #1;
        check("rst_wr_x12_zero", rs1_data, 32'h0);
        check("rst_wr_x10_zero", rs2_data, 32'h0);
        tick();
        check("rst_wr_x12_still_zero", rs1_data, 32'h0);
        wr(5'd12, 32'h00000099);
        check("rst_wr_x12_landed", rs1_data, 32'h00000099);
        check("rst_wr_x12_landed_nb", rs1_data_nb, 32'h00000099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile.md
Name: rv32i_regfile

Overview:
- 32 x 32-bit integer register file for the RV32I core; directly downstream of the MEM/WB pipeline register.
- Consumes that register's write-back data, write enable and destination address.
- Supplies two combinational read ports (rs1/rs2) to the decode stage.
- Provides an internal write-to-read bypass, so a value being written back is visible to decode in the same cycle without an extra forwarding path.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads see only stored contents.

Ports:
- clk  input  1  core clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; 0 clears the array.
- werf_in  input  1  write enable from the MEM/WB stage.
- write_addr_in  input  ADDR_W  destination register index (rd).
- wb_data_in  input  DATA_W  write-back data.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  DATA_W  read port 1 data, combinational.
- rs2_data  output  DATA_W  read port 2 data, combinational.

Behaviour:
- Storage: registers x1..x(2**ADDR_W-1) are flops; x0 has no storage and is constant 0.
- Reset:
  - reset=0 asynchronously clears every stored register to 0, independent of clk.
  - While reset=0: writes are ignored; rs1_data and rs2_data read 0 for every address.
  - Bypass is suppressed during reset.
- Write:
  - On the rising clk edge with reset=1, werf_in=1 and write_addr_in!=0, reg[write_addr_in] <= wb_data_in.
  - Write latency is one edge.
  - werf_in=0, or write_addr_in=0, leaves the array unchanged.
- Read:
  - Purely combinational from rs*_addr; zero-cycle latency.
  - rsN_addr=0 returns 0 unconditionally, even if a write targets x0.
- Bypass (BYPASS=1):
  - If reset=1, werf_in=1, write_addr_in!=0 and write_addr_in==rsN_addr, then rsN_data = wb_data_in in that same cycle.
  - Otherwise rsN_data = reg[rsN_addr].
  - The bypass applies to each port independently; both ports may bypass simultaneously when they read the same rd.
- BYPASS=0: the read returns the old stored value until the edge; the new value is visible from the cycle after the write.
- Simultaneous events:
  - A write and two reads in one cycle are all legal.
  - Reads never block writes.
  - Only one write port exists, so no write-write conflict is possible.
- Reset mid-operation: asserting reset in the same cycle as a pending write drops the write. After deassertion, the array stays all-zero until the next qualifying edge.
- Reset release: the first write takes effect on the first rising edge sampled with reset=1.
- No X propagation: every output is driven to a defined value for every input combination after reset has been applied once.

Test Plan:
- Reset clear: preload x5=0xDEADBEEF, pulse reset=0 between clock edges -> rs1_addr=5 reads 0 immediately, without waiting for an edge; all 31 registers read 0 after release.
- Basic write/read: werf_in=1, write_addr_in=10, wb_data_in=0x12345678 at edge N; at N+1 rs1_addr=rs2_addr=10 -> both 0x12345678.
- x0 immunity: werf_in=1, write_addr_in=0, wb_data_in=0xFFFFFFFF -> rs1_addr=0 reads 0 in the same cycle and every later cycle; no other register changes.
- Bypass:
  - Stored x7=0x1; in cycle C drive werf_in=1, write_addr_in=7, wb_data_in=0xA5A5A5A5, rs1_addr=7, rs2_addr=8 -> rs1_data=0xA5A5A5A5 within C, rs2_data=reg[8].
  - With BYPASS=0 -> rs1_data=0x1 in C and 0xA5A5A5A5 in C+1.
- Write disabled: werf_in=0, write_addr_in=3, wb_data_in=0x55 -> x3 unchanged and no bypass (rs1_addr=3 returns the stored value).
- Reset during write: werf_in=1, write_addr_in=12, wb_data_in=0x99 with reset=0 across the edge -> after release x12 reads 0; the next write with reset=1 to x12 lands normally.
